// File: rtl/cpu_mem_bridge.sv
// Bridges the CPU fetch and data channels onto one single-port memory bus.
// One bus transaction is in flight at a time. Read responses are buffered until the
// CPU accepts them, and a watchdog turns a lost read response into an error word.
module cpu_mem_bridge #(
  parameter int unsigned TIMEOUT  = 1023,
  parameter logic [31:0] ERR_DATA = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  // Instruction fetch channel
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  // Data channel
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  // Shared memory bus
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] timeout_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAck,
    StWait,
    StRsp
  } state_e;

  state_e      state_q;
  logic        sel_q;          // 1: fetch owns the transaction, 0: data channel
  logic [31:0] addr_q;
  logic        wen_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] buf_q;          // response buffer, also holds ERR_DATA on timeout
  logic [31:0] wdog_q;
  logic [31:0] timeout_cnt_q;

  // The bus is word addressed; the low address bits carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Address[1:0], PC[1:0]};

  // Transaction FSM: arbitration, latching, bus handshake, watchdog and response buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      sel_q         <= 1'b0;
      addr_q        <= '0;
      wen_q         <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      buf_q         <= '0;
      wdog_q        <= '0;
      timeout_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Data beats fetch; a read+write collision is treated as a write.
          if (MemRead || MemWrite) begin
            sel_q   <= 1'b0;
            addr_q  <= {Address[31:2], 2'b00};
            wen_q   <= MemWrite;
            wdata_q <= MemWrite ? Write_data : '0;
            wstrb_q <= MemWrite ? Write_strb : '0;
            state_q <= StReq;
          end else if (Inst_Req_Valid) begin
            sel_q   <= 1'b1;
            addr_q  <= {PC[31:2], 2'b00};
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (mem_req_ready) state_q <= StAck;
        end
        StAck: begin
          if (wen_q) begin
            state_q <= StIdle;
          end else begin
            wdog_q  <= '0;
            state_q <= StWait;
          end
        end
        StWait: begin
          // A response in the same cycle as the timeout wins.
          if (mem_rsp_valid) begin
            buf_q   <= mem_rdata;
            state_q <= StRsp;
          end else if (wdog_q == 32'(TIMEOUT)) begin
            buf_q   <= ERR_DATA;
            if (timeout_cnt_q != '1) timeout_cnt_q <= timeout_cnt_q + 32'd1;
            state_q <= StRsp;
          end else begin
            wdog_q <= wdog_q + 32'd1;
          end
        end
        StRsp: begin
          if (sel_q ? Inst_Ready : Read_data_Ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode only the state and latched fields, never the CPU inputs.
  assign mem_req_valid   = (state_q == StReq);
  assign mem_addr        = addr_q;
  assign mem_wen         = wen_q;
  assign mem_wdata       = wdata_q;
  assign mem_wstrb       = wstrb_q;

  assign Inst_Req_Ready  = (state_q == StAck) &&  sel_q;
  assign Mem_Req_Ready   = (state_q == StAck) && !sel_q;
  assign Inst_Valid      = (state_q == StRsp) &&  sel_q;
  assign Read_data_Valid = (state_q == StRsp) && !sel_q;
  assign Instruction     = buf_q;
  assign Read_data       = buf_q;
  assign timeout_cnt     = timeout_cnt_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Self-checking bench for cpu_mem_bridge with a scoreboard of expected responses.
module tb_cpu_mem_bridge;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        Inst_Req_Valid, Inst_Req_Ready, Inst_Valid, Inst_Ready;
  logic [31:0] Instruction;
  logic [31:0] Address, Write_data, Read_data;
  logic        MemWrite, MemRead, Mem_Req_Ready, Read_data_Valid, Read_data_Ready;
  logic [3:0]  Write_strb;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, timeout_cnt;
  logic [3:0]  mem_wstrb;

  typedef struct packed {
    logic        sel;   // 1: fetch, 0: load
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  logic        rsp_en;
  int          rsp_delay;
  logic        late_req;
  logic [31:0] rsp_addr;

  always #5 clk = ~clk;

  cpu_mem_bridge #(
    .TIMEOUT (TO),
    .ERR_DATA(ERR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .PC             (PC),
    .Inst_Req_Valid (Inst_Req_Valid),
    .Inst_Req_Ready (Inst_Req_Ready),
    .Instruction    (Instruction),
    .Inst_Valid     (Inst_Valid),
    .Inst_Ready     (Inst_Ready),
    .Address        (Address),
    .MemWrite       (MemWrite),
    .Write_data     (Write_data),
    .Write_strb     (Write_strb),
    .MemRead        (MemRead),
    .Mem_Req_Ready  (Mem_Req_Ready),
    .Read_data      (Read_data),
    .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rdata      (mem_rdata),
    .timeout_cnt    (timeout_cnt)
  );

  // Memory contents seen by the bus model.
  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0], 16'h0000} ^ 32'h1357_9BDF;
  endfunction

  // Bus responder: answers an accepted read rsp_delay cycles after the first WAIT cycle.
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(negedge clk);
      if (late_req) begin
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
      end else if (rsp_en && mem_req_valid && mem_req_ready && !mem_wen) begin
        rsp_addr = mem_addr;
        @(posedge clk);
        repeat (rsp_delay) @(posedge clk);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1;
        mem_rdata     = model_rdata(rsp_addr);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; PC = '0; Inst_Req_Valid = 1'b0; Inst_Ready = 1'b1;
    Address = '0; MemWrite = 1'b0; Write_data = '0; Write_strb = '0; MemRead = 1'b0;
    Read_data_Ready = 1'b1; mem_req_ready = 1'b1;
    rsp_en = 1'b1; rsp_delay = 0; late_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid, mem_req_valid, mem_wen,
         mem_wstrb, mem_addr, mem_wdata, Instruction, Read_data, timeout_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs addr=%h wdata=%h buf=%h tcnt=%h flags=%b exp all zero",
               mem_addr, mem_wdata, Read_data, timeout_cnt,
               {Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid, mem_req_valid});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fetch(input logic [31:0] pc);
    exp_q.push_back({1'b1, model_rdata(pc)});
    @(posedge clk); #1;
    PC = pc; Inst_Req_Valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (Inst_Req_Ready !== (c == 2)) begin
        bad++; $display("FAIL fetch_req_ready c=%0d got=%b exp=%b", c, Inst_Req_Ready, c == 2);
      end
      total++;
      if (Inst_Valid !== (c == 4)) begin
        bad++; $display("FAIL fetch_valid c=%0d got=%b exp=%b", c, Inst_Valid, c == 4);
      end
      if (c == 1) begin
        total++;
        if ({mem_req_valid, mem_addr, mem_wstrb, mem_wen} !== {1'b1, pc, 4'b0000, 1'b0}) begin
          bad++; $display("FAIL fetch_bus got v=%b a=%h s=%b w=%b exp v=1 a=%h s=0 w=0",
                          mem_req_valid, mem_addr, mem_wstrb, mem_wen, pc);
        end
      end
      if (c == 4) begin
        e = exp_q.pop_front();
        total++;
        if (Instruction !== e.data || e.sel !== 1'b1) begin
          bad++; $display("FAIL fetch_data got=%h exp=%h sel=%b", Instruction, e.data, e.sel);
        end
      end
      @(posedge clk); #1;
      if (c == 2) Inst_Req_Valid = 1'b0;
    end
  endtask

  // Store, then a fetch presented in the very cycle the FSM is back in IDLE.
  task automatic test_store_back_to_back();
    exp_q.push_back({1'b1, model_rdata(32'h300)});
    @(posedge clk); #1;
    Address = 32'h2002; MemWrite = 1'b1; Write_strb = 4'b1100; Write_data = 32'hABCD_0000;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      total++;
      if (Mem_Req_Ready !== (c == 2)) begin
        bad++; $display("FAIL store_ready c=%0d got=%b exp=%b", c, Mem_Req_Ready, c == 2);
      end
      total++;
      if (Read_data_Valid !== 1'b0) begin
        bad++; $display("FAIL store_no_rsp c=%0d got=%b exp=0", c, Read_data_Valid);
      end
      total++;
      if (mem_req_valid !== (c == 1 || c == 4)) begin
        bad++; $display("FAIL b2b_req_valid c=%0d got=%b exp=%b", c, mem_req_valid,
                        c == 1 || c == 4);
      end
      if (c == 1) begin
        total++;
        if ({mem_addr, mem_wen, mem_wstrb, mem_wdata} !==
            {32'h0000_2000, 1'b1, 4'b1100, 32'hABCD_0000}) begin
          bad++; $display("FAIL store_bus got a=%h w=%b s=%b d=%h exp a=2000 w=1 s=1100 d=abcd0000",
                          mem_addr, mem_wen, mem_wstrb, mem_wdata);
        end
      end
      if (c == 4) begin
        total++;
        if ({mem_addr, mem_wen, mem_wstrb} !== {32'h0000_0300, 1'b0, 4'b0000}) begin
          bad++; $display("FAIL b2b_bus got a=%h w=%b s=%b exp a=300 w=0 s=0",
                          mem_addr, mem_wen, mem_wstrb);
        end
      end
      total++;
      if (Inst_Valid !== (c == 7)) begin
        bad++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, Inst_Valid, c == 7);
      end
      if (c == 7) begin
        e = exp_q.pop_front();
        total++;
        if (Instruction !== e.data || e.sel !== 1'b1) begin
          bad++; $display("FAIL b2b_data got=%h exp=%h", Instruction, e.data);
        end
      end
      @(posedge clk); #1;
      if (c == 2) begin
        MemWrite = 1'b0; Write_strb = '0; Write_data = '0; PC = 32'h300; Inst_Req_Valid = 1'b1;
      end
      if (c == 5) Inst_Req_Valid = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int req_hs = 0;
    int rsp_hs = 0;
    exp_q.push_back({1'b0, model_rdata(32'h3000)});
    @(posedge clk); #1;
    Address = 32'h3000; MemRead = 1'b1; mem_req_ready = 1'b0; Read_data_Ready = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (Mem_Req_Ready) req_hs++;
      if (Read_data_Valid && Read_data_Ready) rsp_hs++;
      total++;
      if (mem_req_valid !== (c >= 1 && c <= 6)) begin
        bad++; $display("FAIL bp_req_valid c=%0d got=%b", c, mem_req_valid);
      end
      if (c >= 1 && c <= 6) begin
        total++;
        if ({mem_addr, mem_wen, mem_wstrb} !== {32'h0000_3000, 1'b0, 4'b0000}) begin
          bad++; $display("FAIL bp_bus_stable c=%0d got a=%h w=%b s=%b exp a=3000 w=0 s=0",
                          c, mem_addr, mem_wen, mem_wstrb);
        end
      end
      total++;
      if (Read_data_Valid !== (c >= 9 && c <= 12)) begin
        bad++; $display("FAIL bp_rsp_valid c=%0d got=%b", c, Read_data_Valid);
      end
      if (c == 9) e = exp_q.pop_front();
      if (c >= 9 && c <= 12) begin
        total++;
        if (Read_data !== e.data || e.sel !== 1'b0) begin
          bad++; $display("FAIL bp_rsp_stable c=%0d got=%h exp=%h", c, Read_data, e.data);
        end
      end
      @(posedge clk); #1;
      if (c == 5) mem_req_ready = 1'b1;
      if (c == 7) MemRead = 1'b0;
      if (c == 11) Read_data_Ready = 1'b1;
    end
    total++;
    if (req_hs != 1 || rsp_hs != 1) begin
      bad++; $display("FAIL bp_handshakes got req=%0d rsp=%0d exp 1 and 1", req_hs, rsp_hs);
    end
  endtask

  task automatic test_priority();
    exp_q.push_back({1'b0, model_rdata(32'h4000)});
    exp_q.push_back({1'b1, model_rdata(32'h200)});
    @(posedge clk); #1;
    Address = 32'h4000; MemRead = 1'b1; PC = 32'h200; Inst_Req_Valid = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      total++;
      if ({Mem_Req_Ready, Inst_Req_Ready, Read_data_Valid, Inst_Valid} !==
          {c == 2, c == 7, c == 4, c == 9}) begin
        bad++; $display("FAIL prio_flags c=%0d got=%b exp=%b", c,
                        {Mem_Req_Ready, Inst_Req_Ready, Read_data_Valid, Inst_Valid},
                        {c == 2, c == 7, c == 4, c == 9});
      end
      if (c == 1 || c == 6) begin
        total++;
        if (mem_addr !== ((c == 1) ? 32'h4000 : 32'h200)) begin
          bad++; $display("FAIL prio_addr c=%0d got=%h", c, mem_addr);
        end
      end
      if (c == 4 || c == 9) begin
        e = exp_q.pop_front();
        total++;
        if ({Inst_Valid, Read_data_Valid} !== (e.sel ? 2'b10 : 2'b01) ||
            (e.sel ? Instruction : Read_data) !== e.data) begin
          bad++; $display("FAIL prio_order c=%0d got iv=%b dv=%b i=%h d=%h exp sel=%b data=%h",
                          c, Inst_Valid, Read_data_Valid, Instruction, Read_data, e.sel, e.data);
        end
      end
      @(posedge clk); #1;
      if (c == 2) MemRead = 1'b0;
      if (c == 7) Inst_Req_Valid = 1'b0;
    end
  endtask

  // Run 0: no response, error completion. Run 1: response exactly at count TO.
  task automatic test_timeout();
    for (int r = 0; r < 2; r++) begin
      rsp_en    = (r == 1);
      rsp_delay = TO;
      exp_q.push_back({1'b0, (r == 0) ? ERR : model_rdata(32'h5000)});
      @(posedge clk); #1;
      Address = 32'h5000; MemRead = 1'b1;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        total++;
        if (Read_data_Valid !== (c == 12)) begin
          bad++; $display("FAIL to_valid r=%0d c=%0d got=%b exp=%b", r, c, Read_data_Valid,
                          c == 12);
        end
        if (c == 11) begin
          total++;
          if (timeout_cnt !== 32'(r)) begin
            bad++; $display("FAIL to_cnt_before r=%0d got=%0d exp=%0d", r, timeout_cnt, r);
          end
        end
        if (c == 12) begin
          e = exp_q.pop_front();
          total++;
          if (Read_data !== e.data || timeout_cnt !== 32'd1) begin
            bad++; $display("FAIL to_result r=%0d got d=%h cnt=%0d exp d=%h cnt=1",
                            r, Read_data, timeout_cnt, e.data);
          end
        end
        @(posedge clk); #1;
        if (c == 2) MemRead = 1'b0;
      end
    end
    rsp_en = 1'b1; rsp_delay = 0;
  endtask

  task automatic test_reset_mid_wait();
    rsp_en = 1'b0;
    @(posedge clk); #1;
    Address = 32'h6000; MemRead = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 5) begin
        total++;
        if ({Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid, mem_req_valid, mem_wen,
             mem_wstrb, mem_addr, mem_wdata, Read_data, timeout_cnt} !== '0) begin
          bad++; $display("FAIL rst_mid_outputs addr=%h buf=%h tcnt=%0d exp all zero",
                          mem_addr, Read_data, timeout_cnt);
        end
      end
      if (c >= 6) begin
        total++;
        if ({Read_data_Valid, mem_req_valid} !== 2'b00 || Read_data !== 32'h0) begin
          bad++; $display("FAIL rst_late_rsp c=%0d got v=%b rv=%b d=%h exp 0 0 0", c,
                          Read_data_Valid, mem_req_valid, Read_data);
        end
      end
      @(posedge clk); #1;
      if (c == 2) MemRead = 1'b0;
      if (c == 3) rst = 1'b1;
      if (c == 4) begin rst = 1'b0; late_req = 1'b1; end
      if (c == 5) late_req = 1'b0;
    end
    rsp_en = 1'b1;
    test_fetch(32'h100);
  endtask

  initial begin
    test_reset();
    test_fetch(32'h100);
    test_store_back_to_back();
    test_backpressure();
    test_priority();
    test_timeout();
    test_reset_mid_wait();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
